fail_addr_descrambler: RTL and testbench
========================================

// Module: fail_addr_descrambler
// PURPOSE
//  Inverse of the BIST address_generator transform. Takes the physical address
//  (pas) presented to the RAM on a compare failure and recovers the logical
//  counter value (tas) for the active address mode (admd) and direction.
//  Pairs each recovered address with its data-mismatch syndrome and queues the
//  pair in a small fail-log FIFO, drained by the diagnosis/readout port through
//  a valid/ready handshake. Sits between the comparator and the readout.
// PARAMETERS
//  TASW   `ADDR_WIDTH  address width; must be 8 (bit map is fixed); elaboration error otherwise
//  SYNW   8            mismatch syndrome width
//  DEPTH  4            fail-log FIFO entries; power of 2, >=2
// PORTS
//  clk       in   1            rising-edge clock
//  rst_n     in   1            asynchronous active-low reset
//  clr       in   1            sync flush: pipeline, FIFO, ovf, drop_cnt
//  admd_in   in   `ADMD_WIDTH  address mode, `ADMD_* encodings from defines.v
//  updwn_in  in   1            direction; `ADDR_UP = up
//  fail_in   in   1            1-cycle strobe: compare failed this cycle
//  pas_in    in   TASW         physical address of the failing access
//  syn_in    in   SYNW         expected^observed data
//  log_valid out  1            FIFO head valid
//  log_ready in   1            readout accepts head
//  log_tas   out  TASW         recovered logical address at head
//  log_syn   out  SYNW         syndrome at head
//  log_cnt   out  clog2(DEPTH)+1  entries held
//  ovf       out  1            sticky: a fail was dropped
//  drop_cnt  out  8            dropped fails, saturates at 8'hFF
// BEHAVIOUR
//  Reset (async) / clr: all outputs 0, FIFO empty, pipeline valid bits 0.
//  S1: on fail_in register pas, syn, admd, updwn, v1=1; else v1=0.
//  S2: inverse map of S1 regs (comb), registered with v2. Write FIFO when v2.
//  Latency: fail_in at edge N -> log_valid=1 after edge N+2 if FIFO was empty.
//  Back-to-back fail_in accepted every cycle (throughput 1/cycle).
//  Inverse map (d = updwn!=`ADDR_UP):
//   LIUD, PRUD, 2I0, undefined codes: tas = pas.
//   AC: tas[0]=pas[7]^d; tas[i+1]=pas[i]^tas[0], i=0..6.
//   GC: tas[7]=pas[7]^d; tas[i]=pas[i]^tas[i+1], i=6..0 (cascade top-down).
//   2Ik, k=1..7: swap bits 0 and k (self-inverse); others unchanged.
//  FIFO: pop when log_valid&log_ready; head updates next cycle; no bubble.
//   Full & write & no pop: write dropped, ovf<=1, drop_cnt++ (saturating).
//   Full & write & pop same cycle: both occur, no drop, log_cnt unchanged.
//   Empty: log_valid=0, log_tas/log_syn hold last value (don't care).
//   Pointers wrap modulo DEPTH.
//  clr has priority over fail_in and pop in the same cycle.
//  Mode/direction captured with the fail in S1; later admd changes don't
//   affect in-flight entries.
//  Async reset mid-operation discards all in-flight and queued entries.
// STRUCTURE
//  defines.v: `ADMD_* codes, `ADMD_WIDTH, `ADDR_UP, `ADDR_WIDTH (existing).
//  Sub-module address_inverse: pure comb (admd, updwn, pas) -> tas; reused by
//   any future readout or self-check logic. FIFO inline (reg array + ptrs).
// TESTING
//  GC up, pas 8'h07, syn 8'h01 -> 2 cycles later log_tas 8'h05, log_syn 8'h01.
//  GC down pas 8'h87 -> 8'h05; AC up pas 8'hFE -> 8'h03; 2I3 pas 8'h08 -> 8'h01.
//  Round trip: all 256 tas x every mode x both dirs through address_generator
//   model -> log_tas equals original tas, in order.
//  log_ready=0, 6 fails, DEPTH=4 -> log_cnt 4, ovf 1, drop_cnt 2; first 4 kept.
//  Full FIFO, fail_in with log_ready=1 same cycle -> no drop, log_cnt stays 4.
//  clr and rst_n pulse mid-burst -> log_valid 0 next cycle, ovf 0, drop_cnt 0.

Source files
------------

// File: rtl/fail_addr_descrambler_pkg.sv
// Shared address-mode encodings and widths for the fail-address descrambler
// and any other logic that needs to undo the BIST address_generator transform.
package fail_addr_descrambler_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int ADMD_WIDTH = 4;
  localparam logic ADDR_UP = 1'b1;

  // Codes 12..15 are unused and decode as identity.
  typedef enum logic [ADMD_WIDTH-1:0] {
    ADMD_LIUD = 4'd0,
    ADMD_PRUD = 4'd1,
    ADMD_AC   = 4'd2,
    ADMD_GC   = 4'd3,
    ADMD_2I0  = 4'd4,
    ADMD_2I1  = 4'd5,
    ADMD_2I2  = 4'd6,
    ADMD_2I3  = 4'd7,
    ADMD_2I4  = 4'd8,
    ADMD_2I5  = 4'd9,
    ADMD_2I6  = 4'd10,
    ADMD_2I7  = 4'd11
  } admd_e;

  function automatic logic is_swap_mode(logic [ADMD_WIDTH-1:0] admd);
    return (admd >= ADMD_2I1) && (admd <= ADMD_2I7);
  endfunction

endpackage

// File: rtl/fail_addr_descrambler_address_inverse.sv
// Pure combinational inverse of the address_generator mapping:
// physical address (pas) back to the logical counter value (tas).
module address_inverse
  import fail_addr_descrambler_pkg::*;
(
  input  logic [ADMD_WIDTH-1:0] admd,
  input  logic                  updwn,
  input  logic [ADDR_WIDTH-1:0] pas,
  output logic [ADDR_WIDTH-1:0] tas
);

  logic                  dir_down;
  logic [ADMD_WIDTH-1:0] swap_sel;
  logic [2:0]            swap_bit;

  assign dir_down = (updwn != ADDR_UP);
  assign swap_sel = admd - 4'(ADMD_2I0);
  assign swap_bit = swap_sel[2:0];

  always_comb begin
    tas = pas;
    if (admd == ADMD_AC) begin
      tas[0] = pas[7] ^ dir_down;
      for (int i = 0; i < 7; i++) begin
        tas[i+1] = pas[i] ^ tas[0];
      end
    end else if (admd == ADMD_GC) begin
      // Gray decode must ripple from the MSB down.
      tas[7] = pas[7] ^ dir_down;
      for (int i = 6; i >= 0; i--) begin
        tas[i] = pas[i] ^ tas[i+1];
      end
    end else if (is_swap_mode(admd)) begin
      tas[0]        = pas[swap_bit];
      tas[swap_bit] = pas[0];
    end
  end

endmodule

// File: rtl/fail_addr_descrambler.sv
// Recovers the logical address of each compare failure and queues it with its
// syndrome in a small fail-log FIFO drained through a valid/ready port.
module fail_addr_descrambler
  import fail_addr_descrambler_pkg::*;
#(
  parameter int TASW  = ADDR_WIDTH,
  parameter int SYNW  = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [ADMD_WIDTH-1:0]      admd_in,
  input  logic                       updwn_in,
  input  logic                       fail_in,
  input  logic [TASW-1:0]            pas_in,
  input  logic [SYNW-1:0]            syn_in,
  output logic                       log_valid,
  input  logic                       log_ready,
  output logic [TASW-1:0]            log_tas,
  output logic [SYNW-1:0]            log_syn,
  output logic [$clog2(DEPTH):0]     log_cnt,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (TASW != ADDR_WIDTH) begin : g_tasw_check
    $error("fail_addr_descrambler: TASW must be 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fail_addr_descrambler: DEPTH must be a power of 2 and >= 2");
  end

  logic                  v1;
  logic [TASW-1:0]       s1_pas;
  logic [SYNW-1:0]       s1_syn;
  logic [ADMD_WIDTH-1:0] s1_admd;
  logic                  s1_updwn;
  logic [TASW-1:0]       inv_tas;

  logic                  v2;
  logic [TASW-1:0]       s2_tas;
  logic [SYNW-1:0]       s2_syn;

  logic [TASW-1:0]       mem_tas [DEPTH];
  logic [SYNW-1:0]       mem_syn [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Mode and direction travel with the fail so later admd changes are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_pas   <= '0;
      s1_syn   <= '0;
      s1_admd  <= '0;
      s1_updwn <= 1'b0;
    end else if (clr) begin
      v1       <= 1'b0;
      s1_pas   <= '0;
      s1_syn   <= '0;
      s1_admd  <= '0;
      s1_updwn <= 1'b0;
    end else begin
      v1 <= fail_in;
      if (fail_in) begin
        s1_pas   <= pas_in;
        s1_syn   <= syn_in;
        s1_admd  <= admd_in;
        s1_updwn <= updwn_in;
      end
    end
  end

  address_inverse u_address_inverse (
    .admd  (s1_admd),
    .updwn (s1_updwn),
    .pas   (s1_pas),
    .tas   (inv_tas)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      s2_tas <= '0;
      s2_syn <= '0;
    end else if (clr) begin
      v2     <= 1'b0;
      s2_tas <= '0;
      s2_syn <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2_tas <= inv_tas;
        s2_syn <= s1_syn;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
  assign log_valid = (log_cnt != '0);
  assign full      = (log_cnt == CW'(DEPTH));
  assign pop       = log_valid & log_ready;
  assign push      = v2 & (~full | pop);
  assign drop      = v2 & full & ~pop;
  assign log_tas   = mem_tas[rd_ptr];
  assign log_syn   = mem_syn[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      log_cnt  <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_tas[i] <= '0;
        mem_syn[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      log_cnt  <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_tas[i] <= '0;
        mem_syn[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_tas[wr_ptr] <= s2_tas;
        mem_syn[wr_ptr] <= s2_syn;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        log_cnt <= log_cnt + 1'b1;
      end else if (pop && !push) begin
        log_cnt <= log_cnt - 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fail_addr_descrambler.sv
// Directed, table-driven bench for fail_addr_descrambler: known vectors,
// full mode/direction round trip, and FIFO overflow / flush corner cases.
module tb_fail_addr_descrambler;
  import fail_addr_descrambler_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [3:0] admd_in;
  logic       updwn_in;
  logic       fail_in;
  logic [7:0] pas_in;
  logic [7:0] syn_in;
  logic       log_valid;
  logic       log_ready;
  logic [7:0] log_tas;
  logic [7:0] log_syn;
  logic [2:0] log_cnt;
  logic       ovf;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [3:0] admd;
    logic       updwn;
    logic [7:0] pas;
    logic [7:0] syn;
    logic [7:0] tas;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  fail_addr_descrambler #(.TASW(8), .SYNW(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .admd_in   (admd_in),
    .updwn_in  (updwn_in),
    .fail_in   (fail_in),
    .pas_in    (pas_in),
    .syn_in    (syn_in),
    .log_valid (log_valid),
    .log_ready (log_ready),
    .log_tas   (log_tas),
    .log_syn   (log_syn),
    .log_cnt   (log_cnt),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  // Forward address_generator model, written independently of the inverse.
  function automatic logic [7:0] fwd(input logic [3:0] m, input logic u, input logic [7:0] t);
    logic [7:0] p;
    logic       d;
    int         k;
    d = (u != ADDR_UP);
    p = t;
    if (m == 4'd2) begin
      p[7] = t[0] ^ d;
      for (int i = 0; i < 7; i++) p[i] = t[i+1] ^ t[0];
    end else if (m == 4'd3) begin
      p[7] = t[7] ^ d;
      for (int i = 0; i < 7; i++) p[i] = t[i] ^ t[i+1];
    end else if (m >= 4'd5 && m <= 4'd11) begin
      k    = int'(m) - 4;
      p[0] = t[k];
      p[k] = t[0];
    end
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One-cycle fail strobe; mode/dir/pas are scrambled afterwards to prove capture.
  task automatic applyStimulus(input logic [3:0] m, input logic u, input logic [7:0] p,
                               input logic [7:0] s);
    admd_in  = m;
    updwn_in = u;
    pas_in   = p;
    syn_in   = s;
    fail_in  = 1'b1;
    step();
    fail_in  = 1'b0;
    admd_in  = m ^ 4'hF;
    updwn_in = ~u;
    pas_in   = ~p;
    syn_in   = ~s;
  endtask

  task automatic doClear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic checkEmptyState(input string tag);
    checkOutput({tag, "_valid"}, 32'(log_valid), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(log_cnt), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
    checkOutput({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'd3,  1'b1, 8'h07, 8'h01, 8'h05};
    vecs[1]  = '{4'd3,  1'b0, 8'h87, 8'h02, 8'h05};
    vecs[2]  = '{4'd2,  1'b1, 8'hFE, 8'h03, 8'h03};
    vecs[3]  = '{4'd7,  1'b1, 8'h08, 8'h04, 8'h01};
    vecs[4]  = '{4'd0,  1'b1, 8'hA5, 8'h05, 8'hA5};
    vecs[5]  = '{4'd1,  1'b0, 8'h3C, 8'h06, 8'h3C};
    vecs[6]  = '{4'd4,  1'b1, 8'h81, 8'h07, 8'h81};
    vecs[7]  = '{4'd11, 1'b1, 8'h80, 8'h08, 8'h01};
    vecs[8]  = '{4'd14, 1'b0, 8'h6B, 8'h09, 8'h6B};
    vecs[9]  = '{4'd2,  1'b0, 8'h00, 8'h0A, 8'hFF};
    vecs[10] = '{4'd3,  1'b0, 8'hFF, 8'h0B, 8'h55};
    vecs[11] = '{4'd5,  1'b1, 8'h02, 8'h0C, 8'h01};

    rst_n = 1'b0; clr = 1'b0; admd_in = '0; updwn_in = 1'b0; fail_in = 1'b0;
    pas_in = '0; syn_in = '0; log_ready = 1'b0;
    step();
    step();
    checkEmptyState("reset");
    checkOutput("reset_tas", 32'(log_tas), 32'd0);
    checkOutput("reset_syn", 32'(log_syn), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors with latency check.
    log_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].admd, vecs[i].updwn, vecs[i].pas, vecs[i].syn);
      step();
      checkOutput($sformatf("vec%0d_early", i), 32'(log_valid), 32'd0);
      step();
      checkOutput($sformatf("vec%0d_valid", i), 32'(log_valid), 32'd1);
      checkOutput($sformatf("vec%0d_tas", i), 32'(log_tas), 32'(vecs[i].tas));
      checkOutput($sformatf("vec%0d_syn", i), 32'(log_syn), 32'(vecs[i].syn));
      step();
    end
    checkOutput("vec_drained", 32'(log_valid), 32'd0);

    // Round trip: every mode (incl. unused codes), both directions, all addresses.
    for (int m = 0; m < 16; m++) begin
      for (int u = 0; u < 2; u++) begin
        for (int t = 0; t < 256; t++) begin
          admd_in  = 4'(m);
          updwn_in = 1'(u);
          pas_in   = fwd(4'(m), 1'(u), 8'(t));
          syn_in   = 8'(t + m * 16 + u);
          fail_in  = 1'b1;
          exp_q.push_back({8'(t), syn_in});
          step();
          if (log_valid) begin
            if (exp_q.size() == 0) checkOutput("rt_extra", 32'd1, 32'd0);
            else checkOutput("roundtrip", 32'({log_tas, log_syn}), 32'(exp_q.pop_front()));
          end
        end
      end
    end
    fail_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (log_valid) begin
        if (exp_q.size() == 0) checkOutput("rt_extra", 32'd1, 32'd0);
        else checkOutput("roundtrip", 32'({log_tas, log_syn}), 32'(exp_q.pop_front()));
      end
    end
    checkOutput("rt_missing", 32'(exp_q.size()), 32'd0);

    // Overflow: 6 fails into a stalled 4-deep FIFO.
    doClear();
    log_ready = 1'b0;
    admd_in = 4'd0; updwn_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pas_in = 8'(8'h10 + i); syn_in = 8'(8'hA0 + i); fail_in = 1'b1;
      step();
    end
    fail_in = 1'b0;
    step();
    step();
    checkOutput("ovf_cnt", 32'(log_cnt), 32'd4);
    checkOutput("ovf_flag", 32'(ovf), 32'd1);
    checkOutput("ovf_drop", 32'(drop_cnt), 32'd2);
    log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_kept%0d_tas", i), 32'(log_tas), 32'(8'h10 + i));
      checkOutput($sformatf("ovf_kept%0d_syn", i), 32'(log_syn), 32'(8'hA0 + i));
      step();
    end
    log_ready = 1'b0;
    checkOutput("ovf_empty", 32'(log_valid), 32'd0);
    checkOutput("ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO with write and pop landing on the same edge.
    doClear();
    checkEmptyState("clr");
    for (int i = 0; i < 4; i++) begin
      pas_in = 8'(8'h20 + i); syn_in = 8'(i); fail_in = 1'b1;
      step();
    end
    fail_in = 1'b0;
    step();
    step();
    checkOutput("full_cnt", 32'(log_cnt), 32'd4);
    pas_in = 8'h24; syn_in = 8'd4; fail_in = 1'b1;
    step();
    fail_in = 1'b0;
    step();
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    checkOutput("fullpop_cnt", 32'(log_cnt), 32'd4);
    checkOutput("fullpop_ovf", 32'(ovf), 32'd0);
    checkOutput("fullpop_drop", 32'(drop_cnt), 32'd0);
    log_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("fullpop_order%0d", i), 32'(log_tas), 32'(8'h20 + i));
      step();
    end
    log_ready = 1'b0;

    // Drop counter saturation.
    doClear();
    fail_in = 1'b1;
    for (int i = 0; i < 300; i++) step();
    fail_in = 1'b0;
    step();
    step();
    checkOutput("sat_drop", 32'(drop_cnt), 32'hFF);
    checkOutput("sat_cnt", 32'(log_cnt), 32'd4);
    checkOutput("sat_ovf", 32'(ovf), 32'd1);

    // clr mid-burst, colliding with fail_in and pop.
    fail_in = 1'b1;
    step();
    step();
    clr = 1'b1; log_ready = 1'b1;
    step();
    clr = 1'b0; fail_in = 1'b0; log_ready = 1'b0;
    checkEmptyState("clrburst");
    step(); step(); step();
    checkOutput("clrburst_flushed", 32'(log_cnt), 32'd0);

    // Async reset mid-burst.
    fail_in = 1'b1;
    for (int i = 0; i < 6; i++) step();
    #2 rst_n = 1'b0;
    #1;
    checkEmptyState("rstburst");
    step();
    fail_in = 1'b0;
    rst_n = 1'b1;
    step(); step(); step();
    checkOutput("rstburst_flushed", 32'(log_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
